// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the programmable interrupt controller:
// register window offsets, FSM states and CUR register layout.
package int_ctrl_pkg;

   localparam logic [2:0] OFF_PEND  = 3'd0;
   localparam logic [2:0] OFF_MASK  = 3'd1;
   localparam logic [2:0] OFF_MODE  = 3'd2;
   localparam logic [2:0] OFF_CUR   = 3'd3;
   localparam logic [2:0] OFF_CLAIM = 3'd4;
   localparam logic [2:0] OFF_EOI   = 3'd5;

   localparam int CUR_VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Processor bus seen by the interrupt controller: the CPU drives address,
// write data and strobe, the controller returns combinational read data.
interface int_ctrl_if;

   logic [31:0] PrAddr;
   logic [31:0] PrWD;
   logic        we;
   logic [31:0] PrRD;

   modport master (
      output PrAddr,
      output PrWD,
      output we,
      input  PrRD
   );

   modport slave (
      input  PrAddr,
      input  PrWD,
      input  we,
      output PrRD
   );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is active and the
// index of the lowest-numbered active request.
module int_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] act,
   output logic         any,
   output logic [4:0]   id
);

   // Scanning from the top down lets the lowest set index overwrite the rest.
   always_comb begin
      any = 1'b0;
      id  = 5'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (act[i]) begin
            any = 1'b1;
            id  = 5'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: latches source requests, applies mask and
// edge/level mode, and runs the claim / end-of-interrupt handshake.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int          NSRC      = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
   parameter int          INT_LINE  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   int_ctrl_if.slave       bus,
   output logic [5:0]      HWInt
);

   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_mode;
   logic [NSRC-1:0] r_irqPrev;
   logic            r_curValid;
   logic [4:0]      r_curId;
   logic [5:0]      r_hwInt;
   state_t          r_state;
   state_t          w_stateNext;

   logic [2:0]      w_off;
   logic            w_hit;
   logic            w_wrPend;
   logic            w_wrMask;
   logic            w_wrMode;
   logic            w_claim;
   logic            w_eoi;
   logic            w_claimOk;
   logic [NSRC-1:0] w_wd;
   logic [NSRC-1:0] w_act;
   logic            w_any;
   logic [4:0]      w_id;
   logic [NSRC-1:0] w_edgeSet;
   logic [NSRC-1:0] w_claimHot;
   logic [NSRC-1:0] w_clr;
   logic [5:0]      w_hwIntNext;
   logic            w_unused;

   assign w_off    = bus.PrAddr[4:2];
   assign w_hit    = (bus.PrAddr[31:5] == BASE_ADDR[31:5]) && (w_off <= OFF_EOI);
   assign w_wrPend = bus.we && w_hit && (w_off == OFF_PEND);
   assign w_wrMask = bus.we && w_hit && (w_off == OFF_MASK);
   assign w_wrMode = bus.we && w_hit && (w_off == OFF_MODE);
   assign w_claim  = bus.we && w_hit && (w_off == OFF_CLAIM);
   assign w_eoi    = bus.we && w_hit && (w_off == OFF_EOI);
   assign w_wd     = bus.PrWD[NSRC-1:0];
   assign w_unused = ^{bus.PrAddr[1:0], bus.PrWD};

   assign w_act     = r_pend & r_mask;
   assign w_claimOk = (r_state == REQ) && w_claim;

   int_prio_enc #(
      .N(NSRC)
   ) u_prio (
      .act(w_act),
      .any(w_any),
      .id (w_id)
   );

   // Edge sources may be cleared by W1C or by claiming them; a fresh edge wins.
   assign w_edgeSet  = irq_src & ~r_irqPrev;
   assign w_claimHot = (w_claimOk && w_any) ? (NSRC'(1) << w_id) : '0;
   assign w_clr      = (w_wrPend ? w_wd : '0) | w_claimHot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irqPrev <= '0;
         r_pend    <= '0;
         r_mask    <= '0;
         r_mode    <= '0;
      end else begin
         r_irqPrev <= irq_src;
         r_pend    <= (r_mode & (w_edgeSet | (r_pend & ~w_clr))) | (~r_mode & irq_src);
         if (w_wrMask) r_mask <= w_wd;
         if (w_wrMode) r_mode <= w_wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_curValid <= 1'b0;
         r_curId    <= '0;
      end else if (w_claimOk) begin
         r_curValid <= w_any;
         r_curId    <= w_any ? w_id : 5'd0;
      end else if ((r_state == SERVICE) && w_eoi) begin
         r_curValid <= 1'b0;
         r_curId    <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   // A claim that finds nothing active falls back to IDLE instead of SERVICE.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_any) w_stateNext = REQ;
         REQ: begin
            if (w_claim)     w_stateNext = w_any ? SERVICE : IDLE;
            else if (!w_any) w_stateNext = IDLE;
         end
         SERVICE: if (w_eoi) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_comb begin
      w_hwIntNext           = '0;
      w_hwIntNext[INT_LINE] = (r_state == REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_hwInt <= '0;
      else     r_hwInt <= w_hwIntNext;
   end

   assign HWInt = r_hwInt;

   always_comb begin
      bus.PrRD = '0;
      if (w_hit) begin
         case (w_off)
            OFF_PEND: bus.PrRD = 32'(r_pend);
            OFF_MASK: bus.PrRD = 32'(r_mask);
            OFF_MODE: bus.PrRD = 32'(r_mode);
            OFF_CUR: begin
               bus.PrRD[CUR_VALID_BIT] = r_curValid;
               bus.PrRD[4:0]           = r_curId;
            end
            default: bus.PrRD = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed handshake scenarios followed by
// random bus traffic, all compared against a behavioural controller model.
module tb_int_ctrl;

   localparam int          NSRC     = 8;
   localparam logic [31:0] BASE     = 32'h0000_7F20;
   localparam int          INT_LINE = 0;

   localparam logic [31:0] A_PEND  = BASE + 32'h00;
   localparam logic [31:0] A_MASK  = BASE + 32'h04;
   localparam logic [31:0] A_MODE  = BASE + 32'h08;
   localparam logic [31:0] A_CUR   = BASE + 32'h0C;
   localparam logic [31:0] A_CLAIM = BASE + 32'h10;
   localparam logic [31:0] A_EOI   = BASE + 32'h14;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] irqSrc;
   logic [5:0]      HWInt;

   int_ctrl_if bus ();

   int_ctrl #(
      .NSRC     (NSRC),
      .BASE_ADDR(BASE),
      .INT_LINE (INT_LINE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .irq_src(irqSrc),
      .bus    (bus),
      .HWInt  (HWInt)
   );

   always #5 clk = ~clk;

   int vectors   = 0;
   int miscompares = 0;

   // Reference model state: what the controller should hold after each edge.
   logic [NSRC-1:0] mPend, mMask, mMode, mPrev;
   logic [31:0]     mCur;
   bit              mWaiting;
   bit              mServing;
   logic [5:0]      expHw;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      mPend    = '0;
      mMask    = '0;
      mMode    = '0;
      mPrev    = '0;
      mCur     = '0;
      mWaiting = 1'b0;
      mServing = 1'b0;
      expHw    = '0;
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (a[31:5] != BASE[31:5] || a[4:2] > 3'd5) return 32'd0;
      case (a[4:2])
         3'd0:    return 32'(mPend);
         3'd1:    return 32'(mMask);
         3'd2:    return 32'(mMode);
         3'd3:    return mCur;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model across one clock edge using the inputs held in that cycle.
   task automatic modelStep(input logic [NSRC-1:0] src, input logic [31:0] addr,
                            input logic [31:0] wd, input bit wr);
      bit              hit;
      int              off;
      int              win;
      bit              found;
      bit              claimAcc;
      bit              w1c;
      logic [NSRC-1:0] newPend;
      hit   = (addr[31:5] == BASE[31:5]) && (addr[4:2] <= 3'd5);
      off   = int'(addr[4:2]);
      found = 1'b0;
      win   = 0;
      for (int i = 0; i < NSRC; i++) begin
         if (!found && mPend[i] && mMask[i]) begin
            found = 1'b1;
            win   = i;
         end
      end
      expHw    = mWaiting ? 6'(1 << INT_LINE) : 6'd0;
      claimAcc = 1'b0;
      w1c      = wr && hit && (off == 0);
      if (mWaiting) begin
         if (wr && hit && off == 4) begin
            claimAcc = found;
            mWaiting = 1'b0;
            mServing = found;
            mCur     = found ? (32'h8000_0000 | 32'(win)) : 32'd0;
         end else if (!found) begin
            mWaiting = 1'b0;
         end
      end else if (mServing) begin
         if (wr && hit && off == 5) begin
            mServing = 1'b0;
            mCur     = 32'd0;
         end
      end else if (found) begin
         mWaiting = 1'b1;
      end
      for (int i = 0; i < NSRC; i++) begin
         if (mMode[i]) begin
            if (src[i] && !mPrev[i])                        newPend[i] = 1'b1;
            else if ((w1c && wd[i]) || (claimAcc && win == i)) newPend[i] = 1'b0;
            else                                            newPend[i] = mPend[i];
         end else begin
            newPend[i] = src[i];
         end
      end
      mPend = newPend;
      mPrev = src;
      if (wr && hit && off == 1) mMask = wd[NSRC-1:0];
      if (wr && hit && off == 2) mMode = wd[NSRC-1:0];
   endtask

   task automatic applyStimulus(input logic [NSRC-1:0] src, input logic [31:0] addr,
                                input logic [31:0] wd, input bit wr);
      irqSrc     = src;
      bus.PrAddr = addr;
      bus.PrWD   = wd;
      bus.we     = wr;
      modelStep(src, addr, wd, wr);
      @(posedge clk);
      #1;
      checkOutput("hwint", 32'(HWInt), 32'(expHw));
      checkOutput("prrd", bus.PrRD, modelRead(addr));
   endtask

   // Reset is raised between edges and its effect checked before any edge.
   task automatic midCycleReset();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_hwint", 32'(HWInt), 32'd0);
      bus.we     = 1'b0;
      bus.PrAddr = A_PEND;
      #1;
      checkOutput("rst_pend", bus.PrRD, 32'd0);
      bus.PrAddr = A_MASK;
      #1;
      checkOutput("rst_mask", bus.PrRD, 32'd0);
      bus.PrAddr = A_CUR;
      #1;
      checkOutput("rst_cur", bus.PrRD, 32'd0);
      rst    = 1'b0;
      irqSrc = '0;
      resetModel();
   endtask

   logic [NSRC-1:0] rSrc;
   logic [31:0]     rAddr;
   logic [31:0]     rWd;
   bit              rWr;

   initial begin
      rst        = 1'b1;
      irqSrc     = '0;
      bus.PrAddr = '0;
      bus.PrWD   = '0;
      bus.we     = 1'b0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("init_hwint", 32'(HWInt), 32'd0);
      bus.PrAddr = A_MODE;
      #1;
      checkOutput("init_mode", bus.PrRD, 32'd0);
      rst = 1'b0;

      $display("[TB] edge source 0 latency and handshake");
      applyStimulus('0, A_MASK, 32'h01, 1'b1);
      applyStimulus('0, A_MODE, 32'h01, 1'b1);
      applyStimulus(8'h01, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s1_hw_n1", 32'(HWInt), 32'd0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s1_hw_n2", 32'(HWInt), 32'd1);
      applyStimulus('0, A_CLAIM, 32'h0, 1'b1);
      applyStimulus('0, A_CUR, 32'h0, 1'b0);
      checkOutput("s1_cur", bus.PrRD, 32'h8000_0000);
      checkOutput("s1_hw_claimed", 32'(HWInt), 32'd0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s1_pend", bus.PrRD, 32'd0);
      applyStimulus('0, A_EOI, 32'h0, 1'b1);
      applyStimulus('0, A_CUR, 32'h0, 1'b0);

      $display("[TB] simultaneous edges on sources 2 and 5");
      applyStimulus('0, A_MASK, 32'hFF, 1'b1);
      applyStimulus('0, A_MODE, 32'hFF, 1'b1);
      applyStimulus(8'h24, A_PEND, 32'h0, 1'b0);
      repeat (3) applyStimulus('0, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_CLAIM, 32'h0, 1'b1);
      applyStimulus('0, A_CUR, 32'h0, 1'b0);
      checkOutput("s2_cur_a", bus.PrRD, 32'h8000_0002);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s2_pend", bus.PrRD, 32'h20);
      applyStimulus('0, A_EOI, 32'h0, 1'b1);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s2_hw_gap", 32'(HWInt), 32'd0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s2_hw_rise", 32'(HWInt), 32'd1);
      applyStimulus('0, A_CLAIM, 32'h0, 1'b1);
      applyStimulus('0, A_CUR, 32'h0, 1'b0);
      checkOutput("s2_cur_b", bus.PrRD, 32'h8000_0005);
      applyStimulus('0, A_EOI, 32'h0, 1'b1);

      $display("[TB] level source 3");
      applyStimulus(8'h08, A_MODE, 32'h00, 1'b1);
      applyStimulus(8'h08, A_MASK, 32'h08, 1'b1);
      repeat (3) applyStimulus(8'h08, A_PEND, 32'h0, 1'b0);
      applyStimulus(8'h08, A_CLAIM, 32'h0, 1'b1);
      applyStimulus(8'h08, A_CUR, 32'h0, 1'b0);
      checkOutput("s3_cur", bus.PrRD, 32'h8000_0003);
      applyStimulus(8'h08, A_EOI, 32'h0, 1'b1);
      applyStimulus(8'h08, A_CUR, 32'h0, 1'b0);
      applyStimulus(8'h08, A_CUR, 32'h0, 1'b0);
      checkOutput("s3_hw_again", 32'(HWInt), 32'd1);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s3_hw_drop", 32'(HWInt), 32'd0);
      applyStimulus('0, A_CLAIM, 32'h0, 1'b1);
      applyStimulus('0, A_CUR, 32'h0, 1'b0);
      checkOutput("s3_cur_ignored", bus.PrRD, 32'd0);

      $display("[TB] W1C racing a new edge");
      applyStimulus('0, A_MODE, 32'h02, 1'b1);
      applyStimulus('0, A_MASK, 32'h00, 1'b1);
      applyStimulus(8'h02, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      applyStimulus(8'h02, A_PEND, 32'h02, 1'b1);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s4_set_wins", bus.PrRD, 32'h02);
      applyStimulus('0, A_PEND, 32'h02, 1'b1);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s4_w1c", bus.PrRD, 32'h00);

      $display("[TB] reset during service");
      applyStimulus('0, A_MODE, 32'h10, 1'b1);
      applyStimulus('0, A_MASK, 32'h10, 1'b1);
      applyStimulus(8'h10, A_PEND, 32'h0, 1'b0);
      repeat (2) applyStimulus('0, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_CLAIM, 32'h0, 1'b1);
      applyStimulus(8'h10, A_PEND, 32'h0, 1'b0);
      applyStimulus('0, A_PEND, 32'h0, 1'b0);
      checkOutput("s5_pend_before", bus.PrRD, 32'h10);
      midCycleReset();
      applyStimulus('0, 32'h0000_7F38, 32'h0, 1'b0);
      applyStimulus('0, 32'h0000_0004, 32'h0, 1'b0);

      $display("[TB] random traffic");
      rSrc = '0;
      for (int c = 0; c < 1500; c++) begin
         rSrc  = rSrc ^ NSRC'($urandom & $urandom & $urandom);
         rWd   = $urandom;
         rWr   = 1'b1;
         case ($urandom_range(0, 9))
            0:       rAddr = A_MASK;
            1:       rAddr = A_MODE;
            2:       rAddr = A_PEND;
            3, 4:    rAddr = A_CLAIM;
            5:       rAddr = A_EOI;
            6:       rAddr = ($urandom_range(0, 1) == 0) ? $urandom : (BASE + 32'(4 * $urandom_range(6, 7)));
            default: begin
               rAddr = BASE + 32'(4 * $urandom_range(0, 7));
               rWr   = 1'b0;
            end
         endcase
         rAddr = rAddr | 32'($urandom_range(0, 3));
         applyStimulus(rSrc, rAddr, rWd, rWr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
